// File: rtl/ad_nios_lcell_count_ctrl.sv
// Avalon register front end and sequencer for the ad_nios hidden-lcell counter chain.
// Optional snapshot register at address 3: define AD_NIOS_CNT_SNAPSHOT_EN.
module ad_nios_lcell_count_ctrl #(
    parameter int unsigned WIDTH    = 16,
    parameter int unsigned PRESCALE = 1
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic [1:0]       address,
    input  logic             chipselect,
    input  logic             write_n,
    input  logic [WIDTH-1:0] writedata,
    output logic [WIDTH-1:0] readdata,
    output logic             irq,
    output logic             cnt_ena,
    output logic             cnt_sload,
    output logic             cnt_sclr,
    output logic [WIDTH-1:0] cnt_data,
    output logic [WIDTH-1:0] count
);

    localparam int unsigned    PW      = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
    localparam logic [PW-1:0]  PS_LAST = PW'(PRESCALE - 1);

    typedef enum logic [1:0] {
        IDLE,
        LOAD,
        COUNT,
        EXPIRE
    } state_t;

    state_t           state;
    logic [WIDTH-1:0] period;
    logic             run;
    logic             cont;
    logic             ito;
    logic             to;
    logic [PW-1:0]    prescaler;

    logic             wr;
    logic             period_wr;
    logic             ctrl_wr;
    logic             stat_wr;
    logic             ps_tick;

    assign wr        = chipselect & ~write_n;
    assign period_wr = wr && (address == 2'd0);
    assign ctrl_wr   = wr && (address == 2'd1);
    assign stat_wr   = wr && (address == 2'd2);
    assign ps_tick   = (prescaler == PS_LAST);

    assign cnt_data  = period;

    // The enable must track the mirror exactly in the same cycle, including a
    // CONTROL write that freezes the count, so it cannot be a lookahead flop.
    assign cnt_ena   = (state == COUNT) && ps_tick && !ctrl_wr && (count != '0);

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            cnt_sclr <= 1'b1;
        end else begin
            cnt_sclr <= 1'b0;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            period <= '1;
        end else if (period_wr) begin
            period <= writedata;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state     <= IDLE;
            run       <= 1'b0;
            cont      <= 1'b0;
            ito       <= 1'b0;
            count     <= '0;
            prescaler <= '0;
            cnt_sload <= 1'b0;
        end else begin
            cnt_sload <= 1'b0;
            case (state)
                IDLE: ;
                LOAD: begin
                    count     <= period;
                    prescaler <= '0;
                    state     <= COUNT;
                end
                COUNT: begin
                    if (!ctrl_wr) begin
                        if (ps_tick) begin
                            prescaler <= '0;
                            if (count == '0) begin
                                state <= EXPIRE;
                            end else begin
                                count <= count - WIDTH'(1);
                            end
                        end else begin
                            prescaler <= prescaler + PW'(1);
                        end
                    end
                end
                EXPIRE: begin
                    if (cont) begin
                        state     <= LOAD;
                        cnt_sload <= 1'b1;
                    end else begin
                        state <= IDLE;
                        run   <= 1'b0;
                    end
                end
                default: state <= IDLE;
            endcase

            // A CONTROL write overrides whatever transition the sequencer chose.
            if (ctrl_wr) begin
                run  <= writedata[0];
                cont <= writedata[1];
                ito  <= writedata[2];
                if (writedata[0]) begin
                    state     <= LOAD;
                    cnt_sload <= 1'b1;
                end else begin
                    state     <= IDLE;
                    cnt_sload <= 1'b0;
                end
            end
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            to  <= 1'b0;
            irq <= 1'b0;
        end else begin
            if (state == EXPIRE) begin
                to <= 1'b1;
            end else if (stat_wr) begin
                to <= 1'b0;
            end
            irq <= to & ito;
        end
    end

    logic [WIDTH-1:0] snap_word;

`ifdef AD_NIOS_CNT_SNAPSHOT_EN
    logic [WIDTH-1:0] snapshot;
    logic             snap_wr;

    assign snap_wr   = wr && (address == 2'd3);
    assign snap_word = snapshot;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            snapshot <= '0;
        end else if (snap_wr) begin
            snapshot <= count;
        end
    end
`else
    assign snap_word = '0;
`endif

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            readdata <= '0;
        end else begin
            case (address)
                2'd0:    readdata <= period;
                2'd1:    readdata <= WIDTH'({ito, cont, run});
                2'd2:    readdata <= WIDTH'({state != IDLE, to});
                default: readdata <= snap_word;
            endcase
        end
    end

endmodule

// File: tb/tb_ad_nios_lcell_count_ctrl.sv
// Directed bench for ad_nios_lcell_count_ctrl; two instances (PRESCALE 1 and 4) share one bus.
module tb_ad_nios_lcell_count_ctrl;

    localparam int W = 16;

    logic         clk = 1'b0;
    logic         reset_n = 1'b0;
    logic [1:0]   address = 2'd0;
    logic         chipselect = 1'b0;
    logic         write_n = 1'b1;
    logic [W-1:0] writedata = '0;

    logic [W-1:0] rd1, data1, count1;
    logic         irq1, ena1, sload1, sclr1;
    logic [W-1:0] rd4, data4, count4;
    logic         irq4, ena4, sload4, sclr4;

    int tests = 0;
    int fails = 0;

    always #5 clk = ~clk;

    ad_nios_lcell_count_ctrl #(.WIDTH(W), .PRESCALE(1)) u1 (
        .clk(clk), .reset_n(reset_n), .address(address), .chipselect(chipselect),
        .write_n(write_n), .writedata(writedata), .readdata(rd1), .irq(irq1),
        .cnt_ena(ena1), .cnt_sload(sload1), .cnt_sclr(sclr1), .cnt_data(data1),
        .count(count1)
    );

    ad_nios_lcell_count_ctrl #(.WIDTH(W), .PRESCALE(4)) u4 (
        .clk(clk), .reset_n(reset_n), .address(address), .chipselect(chipselect),
        .write_n(write_n), .writedata(writedata), .readdata(rd4), .irq(irq4),
        .cnt_ena(ena4), .cnt_sload(sload4), .cnt_sclr(sclr4), .cnt_data(data4),
        .count(count4)
    );

    task automatic tick_n(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic bus_write(input logic [1:0] a, input logic [W-1:0] d);
        address    = a;
        writedata  = d;
        chipselect = 1'b1;
        write_n    = 1'b0;
        @(posedge clk);
        #1;
        chipselect = 1'b0;
        write_n    = 1'b1;
    endtask

    task automatic bus_read(input logic [1:0] a, output logic [W-1:0] r1, output logic [W-1:0] r4);
        address = a;
        @(posedge clk);
        #1;
        r1 = rd1;
        r4 = rd4;
    endtask

    task automatic stop_all();
        bus_write(2'd1, '0);
        bus_write(2'd2, '0);
    endtask

    task automatic test_reset();
        logic [W-1:0] r1, r4;
        #12;
        tests++; if (sclr1 !== 1'b1) begin fails++; $display("FAIL reset_sclr got %0b exp 1", sclr1); end
        tests++; if (irq1 !== 1'b0) begin fails++; $display("FAIL reset_irq got %0b exp 0", irq1); end
        tests++; if (count1 !== 16'd0) begin fails++; $display("FAIL reset_count got %0h exp 0", count1); end
        tests++; if (rd1 !== 16'd0) begin fails++; $display("FAIL reset_readdata got %0h exp 0", rd1); end
        @(posedge clk);
        #1;
        reset_n = 1'b1;
        tests++; if (sclr1 !== 1'b1) begin fails++; $display("FAIL sclr_exit got %0b exp 1", sclr1); end
        tick_n(1);
        tests++; if (sclr1 !== 1'b0) begin fails++; $display("FAIL sclr_after got %0b exp 0", sclr1); end
        bus_read(2'd2, r1, r4);
        tests++; if (r1 !== 16'd0) begin fails++; $display("FAIL reset_status got %0h exp 0", r1); end
        bus_read(2'd0, r1, r4);
        tests++; if (r1 !== 16'hFFFF) begin fails++; $display("FAIL reset_period got %0h exp ffff", r1); end
    endtask

    task automatic test_oneshot();
        logic [W-1:0] r1, r4;
        logic [W-1:0] exp_cnt;
        bus_write(2'd0, 16'd3);
        tests++; if (data1 !== 16'd3) begin fails++; $display("FAIL cnt_data got %0h exp 3", data1); end
        bus_write(2'd1, 16'h1);
        tests++; if (sload1 !== 1'b1) begin fails++; $display("FAIL os_sload got %0b exp 1", sload1); end
        for (int i = 0; i < 4; i++) begin
            tick_n(1);
            exp_cnt = 16'(3 - i);
            tests++; if (count1 !== exp_cnt) begin fails++; $display("FAIL os_count[%0d] got %0d exp %0d", i, count1, exp_cnt); end
            tests++; if (ena1 !== (i != 3)) begin fails++; $display("FAIL os_ena[%0d] got %0b exp %0b", i, ena1, (i != 3)); end
        end
        tick_n(1);
        address = 2'd2;
        tick_n(1);
        tests++; if (rd1 !== 16'd2) begin fails++; $display("FAIL os_status_expire got %0h exp 2", rd1); end
        tick_n(1);
        tests++; if (rd1 !== 16'd1) begin fails++; $display("FAIL os_status_to got %0h exp 1", rd1); end
        bus_read(2'd1, r1, r4);
        tests++; if (r1 !== 16'd0) begin fails++; $display("FAIL os_run_cleared got %0h exp 0", r1); end
        tests++; if (count1 !== 16'd0) begin fails++; $display("FAIL os_count_hold got %0d exp 0", count1); end
    endtask

    task automatic test_continuous_irq();
        int n;
        stop_all();
        bus_write(2'd0, 16'd2);
        bus_write(2'd1, 16'h7);
        tests++; if (sload4 !== 1'b1) begin fails++; $display("FAIL ct_sload got %0b exp 1", sload4); end
        n = 0;
        do begin tick_n(1); n++; end while (!sload4 && n < 40);
        tests++; if (n !== 14) begin fails++; $display("FAIL ct_spacing got %0d exp 14", n); end
        tests++; if (irq4 !== 1'b0) begin fails++; $display("FAIL ct_irq_pre got %0b exp 0", irq4); end
        tick_n(1);
        tests++; if (irq4 !== 1'b1) begin fails++; $display("FAIL ct_irq got %0b exp 1", irq4); end
        bus_write(2'd2, '0);
        tests++; if (irq4 !== 1'b1) begin fails++; $display("FAIL ct_irq_lag got %0b exp 1", irq4); end
        tick_n(1);
        tests++; if (irq4 !== 1'b0) begin fails++; $display("FAIL ct_irq_clr got %0b exp 0", irq4); end
        n = 0;
        do begin tick_n(1); n++; end while (!irq4 && n < 40);
        tests++; if (n !== 12) begin fails++; $display("FAIL ct_irq_again got %0d exp 12", n); end
    endtask

    task automatic test_stop();
        logic [W-1:0] r1, r4;
        int n;
        stop_all();
        bus_write(2'd0, 16'd100);
        bus_write(2'd1, 16'h1);
        n = 0;
        while (count1 !== 16'd57 && n < 120) begin tick_n(1); n++; end
        tests++; if (n !== 44) begin fails++; $display("FAIL st_reach57 got %0d exp 44", n); end
        bus_write(2'd1, '0);
        tests++; if (count1 !== 16'd57) begin fails++; $display("FAIL st_freeze got %0d exp 57", count1); end
        tick_n(3);
        tests++; if (count1 !== 16'd57) begin fails++; $display("FAIL st_hold got %0d exp 57", count1); end
        bus_read(2'd2, r1, r4);
        tests++; if (r1 !== 16'd0) begin fails++; $display("FAIL st_status got %0h exp 0", r1); end
        bus_write(2'd1, 16'h1);
        tests++; if (sload1 !== 1'b1) begin fails++; $display("FAIL st_restart_sload got %0b exp 1", sload1); end
        tick_n(1);
        tests++; if (count1 !== 16'd100) begin fails++; $display("FAIL st_reload got %0d exp 100", count1); end
    endtask

    task automatic test_collision();
        logic [W-1:0] r1, r4;
        stop_all();
        bus_write(2'd0, 16'd1);
        bus_write(2'd1, 16'h1);
        tick_n(3);
        tests++; if (count1 !== 16'd0) begin fails++; $display("FAIL co_count got %0d exp 0", count1); end
        bus_write(2'd2, '0);
        bus_read(2'd2, r1, r4);
        tests++; if (r1 !== 16'd1) begin fails++; $display("FAIL co_to_wins got %0h exp 1", r1); end
    endtask

    task automatic test_period_during_count();
        int n;
        stop_all();
        bus_write(2'd0, 16'd5);
        bus_write(2'd1, 16'h3);
        tick_n(2);
        tests++; if (count1 !== 16'd4) begin fails++; $display("FAIL pw_count_a got %0d exp 4", count1); end
        bus_write(2'd0, 16'd2);
        tests++; if (count1 !== 16'd3) begin fails++; $display("FAIL pw_count_b got %0d exp 3", count1); end
        n = 0;
        do begin tick_n(1); n++; end while (!sload1 && n < 40);
        tests++; if (n !== 5) begin fails++; $display("FAIL pw_old_run got %0d exp 5", n); end
        tick_n(1);
        tests++; if (count1 !== 16'd2) begin fails++; $display("FAIL pw_new_load got %0d exp 2", count1); end
        n = 0;
        do begin tick_n(1); n++; end while (!sload1 && n < 40);
        tests++; if (n !== 4) begin fails++; $display("FAIL pw_new_run got %0d exp 4", n); end
    endtask

    task automatic test_snapshot();
        logic [W-1:0] r1, r4;
        stop_all();
`ifdef AD_NIOS_CNT_SNAPSHOT_EN
        begin
            int n;
            bus_write(2'd0, 16'd20);
            bus_write(2'd1, 16'h1);
            n = 0;
            while (count1 !== 16'd10 && n < 60) begin tick_n(1); n++; end
            tests++; if (count1 !== 16'd10) begin fails++; $display("FAIL sn_reach got %0d exp 10", count1); end
            bus_write(2'd3, 16'h1234);
            tests++; if (count1 !== 16'd9) begin fails++; $display("FAIL sn_count got %0d exp 9", count1); end
            bus_read(2'd3, r1, r4);
            tests++; if (r1 !== 16'd10) begin fails++; $display("FAIL sn_value got %0d exp 10", r1); end
        end
`else
        bus_write(2'd3, 16'hABCD);
        bus_read(2'd3, r1, r4);
        tests++; if (r1 !== 16'd0) begin fails++; $display("FAIL sn_absent got %0h exp 0", r1); end
`endif
        stop_all();
    endtask

    initial begin
        test_reset();
        test_oneshot();
        test_continuous_irq();
        test_stop();
        test_collision();
        test_period_during_count();
        test_snapshot();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog expired");
        $fatal(1, "timeout");
    end

endmodule

// File: doc/ad_nios_lcell_count_ctrl.md
Name: ad_nios_lcell_count_ctrl

Overview:
- Avalon-style register front end and sequencer for the hidden-lcell counter chain in the ad_nios peripheral.
- Holds a programmable period and a clock-enable prescaler.
- Drives the chain's enable, synchronous-load and synchronous-clear strobes, and mirrors the chain count internally for readback, timeout detection and IRQ.
- Sits directly upstream of the lcell counter cells and between them and the Nios data master.

Parameters:
- WIDTH, 16, counter / period width in bits (2..32).
- PRESCALE, 1, clock-enable divide ratio; one count step every PRESCALE clocks (1..65535).

Ports:
- clk  in  1  system clock.
- reset_n  in  1  asynchronous active-low reset.
- address  in  2  register select.
- chipselect  in  1  slave select.
- write_n  in  1  active-low write strobe.
- writedata  in  WIDTH  write data.
- readdata  out  WIDTH  registered read data.
- irq  out  1  interrupt, level, active-high.
- cnt_ena  out  1  count enable to lcell chain.
- cnt_sload  out  1  synchronous load strobe to chain.
- cnt_sclr  out  1  synchronous clear strobe to chain.
- cnt_data  out  WIDTH  load value presented to chain datac inputs.
- count  out  WIDTH  internal mirror of chain count.

Behaviour:
- Clock and reset: one clock (clk); reset is asynchronous and active-low (reset_n).
- Reset values:
  - period = all-ones; RUN=0, CONT=0, ITO=0; TO=0; prescaler=0; count=0; snapshot=0.
  - state IDLE; readdata=0; irq=0.
  - cnt_ena=0, cnt_sload=0, cnt_sclr=1 during reset and for the first clock after deassertion, then 0.
- Register map (write = chipselect & !write_n):
  - 0 PERIOD: R/W reload value; cnt_data = period at all times.
  - 1 CONTROL: bit0 RUN, bit1 CONT (auto-reload), bit2 ITO (IRQ enable).
  - 2 STATUS: bit0 TO (sticky timeout), bit1 RUNNING (state != IDLE); any write clears TO.
  - 3 SNAP: see Optional Feature.
- readdata is registered: it reflects the addressed register one clock after address is presented, regardless of chipselect.
- State machine:
  - IDLE: count held.
    - Write to CONTROL with RUN=1 -> LOAD.
  - LOAD: one cycle; cnt_sload=1; count<=period; prescaler<=0.
    - -> COUNT.
  - COUNT: prescaler increments each clock; when prescaler==PRESCALE-1, cnt_ena=1 for one clock, count decrements, prescaler<=0.
    - count==0 at a tick -> EXPIRE (no decrement; count stays 0, no wrap).
    - RUN cleared -> IDLE immediately; count frozen.
  - EXPIRE: one cycle; TO<=1.
    - CONT=1 -> LOAD.
    - CONT=0 -> IDLE and RUN<=0.
- Period of one timeout = (period+1)*PRESCALE + 2 clocks (LOAD + EXPIRE), measured from LOAD to LOAD in continuous mode.
- PRESCALE=1: cnt_ena is asserted every COUNT cycle.
- period=0: LOAD -> COUNT -> EXPIRE after one prescale interval.
- Write to PERIOD while running: takes effect at the next LOAD only.
- Write to CONTROL with RUN=1 while already running: restarts via LOAD.
- Simultaneous events:
  - STATUS write and EXPIRE in the same cycle: TO ends 1 (set wins).
  - Write to CONTROL clearing RUN in the same cycle as EXPIRE: -> IDLE; TO still set.
- irq = TO & ITO, registered; drops one clock after TO is cleared or ITO is cleared.
- cnt_sclr: asserted only in the reset-exit cycle; the chain is otherwise initialised via sload.

Optional Feature:
- Macro AD_NIOS_CNT_SNAPSHOT_EN.
- Defined:
  - Write of any value to address 3 captures count into the snapshot register on that clock.
  - Read of address 3 returns the snapshot.
  - A capture in the same cycle as a decrement takes the pre-decrement value.
- Undefined: address 3 reads 0, writes are ignored, and no snapshot flops are built.

Test Plan:
- Reset: release reset_n -> cnt_sclr=1 for exactly one clock, readdata=0, irq=0, count=0, STATUS=0.
- One-shot: PRESCALE=1, PERIOD=3, CONTROL=0x1 -> cnt_sload one cycle, then count 3,2,1,0.
  - TO set 6 clocks after LOAD; RUN reads 0 afterwards; count stays 0.
- Continuous with IRQ: PRESCALE=4, PERIOD=2, CONTROL=0x7 -> LOAD-to-LOAD spacing 14 clocks; irq=1 one clock after TO.
  - Write STATUS -> irq=0 next clock; irq re-asserts after the next expiry.
- Stop mid-count: PERIOD=100, run, write CONTROL=0 at count=57 -> count holds 57, RUNNING=0, no TO.
  - Write CONTROL=0x1 -> reload to 100.
- Collision: STATUS write in the EXPIRE cycle -> TO reads 1.
  - PERIOD write during COUNT -> current run unaffected, next reload uses the new value.
- With AD_NIOS_CNT_SNAPSHOT_EN: write addr 3 at count=10 on a tick cycle -> SNAP reads 10, count reads 9.
  - Without the macro: addr 3 reads 0.
